// File: rtl/mips_pkg.sv
// Shared constants and types for the HI/LO multiply/divide unit.
package mips_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_core.sv
// Unsigned radix-2 engine: shift-add multiply or restoring divide, one bit per step.
module muldiv_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     opa,
    input  logic [WIDTH-1:0]     opb,
    output logic                 last_c,
    output logic [2*WIDTH-1:0]   prod,
    output logic [WIDTH-1:0]     quot,
    output logic [WIDTH-1:0]     rem
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   opb_q;
    logic [CNT_W-1:0]   cnt;
    logic               div_q;

    logic [WIDTH:0]     sum_c;
    logic [WIDTH:0]     rsh_c;
    logic [WIDTH:0]     diff_c;

    // Multiply adds into the upper half then shifts right; divide shifts the
    // next dividend bit into the partial remainder and trial-subtracts.
    always_comb begin
        sum_c  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (shreg[0] ? opb_q : '0)};
        rsh_c  = {acc[WIDTH-1:0], shreg[WIDTH-1]};
        diff_c = rsh_c - {1'b0, opb_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            shreg <= '0;
            opb_q <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            acc   <= '0;
            shreg <= opa;
            opb_q <= opb;
            cnt   <= '0;
            div_q <= is_div;
        end else if (step) begin
            cnt <= cnt + 1'b1;
            if (div_q) begin
                acc[WIDTH-1:0] <= diff_c[WIDTH] ? rsh_c[WIDTH-1:0] : diff_c[WIDTH-1:0];
                shreg          <= {shreg[WIDTH-2:0], ~diff_c[WIDTH]};
            end else begin
                acc   <= {sum_c, acc[WIDTH-1:1]};
                shreg <= shreg >> 1;
            end
        end
    end

    assign last_c = (cnt == CNT_W'(WIDTH - 1));
    assign prod   = acc;
    assign quot   = shreg;
    assign rem    = acc[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// MIPS HI/LO multiply/divide unit: control FSM, sign handling, HI/LO and MTHI/MTLO.
module hilo_muldiv
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t          state;
    logic               div_q, sign_a_q, sign_b_q, b_zero_q;

    logic               is_div_c, is_sgn_c, launch_c, last_c;
    logic [WIDTH-1:0]   a_mag_c, b_mag_c;
    logic [2*WIDTH-1:0] prod, prod_fix_c;
    logic [WIDTH-1:0]   quot, rem, quot_fix_c, rem_fix_c, hi_res_c, lo_res_c;

    always_comb begin
        is_div_c = (op == MD_DIV) || (op == MD_DIVU);
        is_sgn_c = (op == MD_MULT) || (op == MD_DIV);
        a_mag_c  = (is_sgn_c && a[WIDTH-1]) ? -a : a;
        b_mag_c  = (is_sgn_c && b[WIDTH-1]) ? -b : b;
        launch_c = (state == IDLE) && start && !abort;
    end

    muldiv_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (launch_c),
        .step   (state == CALC),
        .is_div (is_div_c),
        .opa    (a_mag_c),
        .opb    (b_mag_c),
        .last_c (last_c),
        .prod   (prod),
        .quot   (quot),
        .rem    (rem)
    );

    // Divide by zero leaves the remainder equal to a; the quotient is forced to all ones.
    always_comb begin
        prod_fix_c = (sign_a_q ^ sign_b_q) ? -prod : prod;
        quot_fix_c = (sign_a_q ^ sign_b_q) ? -quot : quot;
        rem_fix_c  = sign_a_q ? -rem : rem;
        hi_res_c   = div_q ? rem_fix_c : prod_fix_c[2*WIDTH-1:WIDTH];
        lo_res_c   = div_q ? (b_zero_q ? '1 : quot_fix_c) : prod_fix_c[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            b_zero_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch_c) begin
                        state    <= CALC;
                        busy     <= 1'b1;
                        div_q    <= is_div_c;
                        sign_a_q <= is_sgn_c & a[WIDTH-1];
                        sign_b_q <= is_sgn_c & b[WIDTH-1];
                        b_zero_q <= (b == '0);
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (last_c) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!abort) begin
                        hi   <= hi_res_c;
                        lo   <= lo_res_c;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit for the MIPS execute stage.
- Owns the HI/LO architectural registers; its hi/lo outputs feed the writeback-select multiplexer that serves MFHI/MFLO.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from decode/execute and stalls the pipeline via busy while iterating.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- abort  input  1  pipeline flush; cancels an in-flight operation.
- busy  output  1  operation in flight; pipeline stalls MFHI/MFLO/new muldiv.
- done  output  1  one-cycle pulse when HI/LO take a new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all internal datapath registers=0.
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - Latch op, the sign flags of a and b, and |a|, |b| (magnitudes only for signed ops; unsigned ops take the raw values).
  - Go to CALC with counter=0; busy=1 from the next cycle.
- CALC: one radix-2 iteration per cycle, counter increments; after WIDTH iterations (counter=WIDTH-1 on the last one) go to FIX.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; produces quotient and remainder.
- FIX:
  - Sign-correct the result.
    - MULT: negate the 2*WIDTH product if sign_a XOR sign_b.
    - DIV: negate the quotient if sign_a XOR sign_b; the remainder takes the sign of a.
  - On exit, load HI=product[2W-1:W] / remainder and LO=product[W-1:0] / quotient.
  - Assert done=1 for exactly the following cycle; busy=0 in that cycle; return to IDLE.
- Latency: start seen at edge E0 → busy high E0..E(WIDTH+1) → new hi/lo and done=1 after edge E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
- Divide by zero (DIV or DIVU): no trap; runs full latency; HI=a (original, unsigned view), LO=all ones.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no exception).
- start while busy: ignored.
- MTHI/MTLO:
  - Single-cycle write in IDLE; visible on hi/lo the next cycle; done stays 0.
  - Ignored while busy.
  - If start and mthi/mtlo are both asserted in IDLE, start wins and the move is dropped.
- Both mthi and mtlo asserted: both registers are written with wdata.
- abort: in CALC or FIX, return to IDLE next cycle, busy=0, done=0, hi/lo unchanged. In IDLE it has no effect, and it overrides a simultaneous start.
- Reset mid-operation: immediate return to IDLE; hi=lo=0; no done pulse.
- hi/lo are register outputs only; no combinational path from inputs.

Decomposition:
- Shared package mips_pkg:
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU 2-bit constants.
  - md_state_t enum (IDLE, CALC, FIX).
- Sub-module muldiv_core: unsigned iterative engine holding the accumulator, the shift registers and the counter.
- Top hilo_muldiv: FSM, sign handling, HI/LO registers, MTHI/MTLO.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done pulses once, busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; then DIV a=0xFFFFFFF9 (-7) b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=10 b=0 → HI=0x0000000A, LO=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF → LO=0x80000000, HI=0.
- mthi wdata=0x12345678 in IDLE → hi=0x12345678 next cycle, done=0. mtlo during CALC → lo unchanged. Second start issued in cycle 5 of a MULT → ignored, first result correct.
- MULTU 7*9 with abort at cycle 10 → busy=0 next cycle, no done, hi/lo keep their prior values. A new start 1 cycle later → correct 63 in LO.
- rst_n low at cycle 20 of DIVU → hi=lo=0, busy=0 immediately (async). After rst_n rises, DIVU 100/7 → LO=14, HI=2.
